if_id_stall_register: RTL and testbench
=======================================

Name: if_id_stall_register

Overview:
- IF/ID pipeline register with an integrated stall/flush controller for the RV32IM 5-stage pipeline.
- Consumes LOAD_USE from the load-use detector and BRANCH_FLUSH from EX.
- Freezes PC and IF/ID for STALL_CYCLES cycles and requests a bubble into ID/EX.
- Converts flushed or stalled-out slots into NOPs so the decode stage never sees a stale instruction.

Parameters:
- XLEN, 32, datapath width of PC and instruction fields.
- STALL_CYCLES, 1, bubble cycles inserted per load-use event; legal range 1..7.
- NOP_INSTR, 32'h00000013, encoding driven on INSTRUCTION_OUT when the slot is invalid (addi x0,x0,0).

Ports:
- CLK  input  1  system clock, rising edge.
- RESET  input  1  asynchronous, active-high reset.
- PC_IN  input  XLEN  PC of the fetched instruction.
- PC_PLUS4_IN  input  XLEN  PC+4 from fetch.
- INSTRUCTION_IN  input  32  fetched instruction.
- LOAD_USE  input  1  hazard flag from the load-use detector, sampled in state RUN only.
- BRANCH_FLUSH  input  1  taken branch/jump resolved in EX.
- PC_OUT  output  XLEN  registered PC to ID.
- PC_PLUS4_OUT  output  XLEN  registered PC+4 to ID.
- INSTRUCTION_OUT  output  32  registered instruction to ID; NOP_INSTR when VALID_OUT=0.
- VALID_OUT  output  1  ID slot holds a real instruction.
- PC_WRITE_EN  output  1  combinational; 0 freezes the PC register.
- ID_EX_BUBBLE  output  1  combinational; 1 forces ID/EX control signals to zero.

Behaviour:
- Reset, asynchronous:
  - PC_OUT=0, PC_PLUS4_OUT=0, INSTRUCTION_OUT=NOP_INSTR, VALID_OUT=0.
  - state=RUN, stall counter=0.
  - Combinational outputs during reset: PC_WRITE_EN=1, ID_EX_BUBBLE=0.
- FSM states: RUN, STALL.
- RUN, BRANCH_FLUSH=1 (flush has priority over LOAD_USE):
  - PC_WRITE_EN=1, ID_EX_BUBBLE=0.
  - Next edge: INSTRUCTION_OUT=NOP_INSTR, VALID_OUT=0; PC fields still load from inputs; stay RUN.
- RUN, LOAD_USE=1, BRANCH_FLUSH=0:
  - Same cycle: PC_WRITE_EN=0, ID_EX_BUBBLE=1.
  - Next edge: IF/ID contents held; counter loads STALL_CYCLES-1.
  - If STALL_CYCLES=1, stay RUN; otherwise go to STALL.
- RUN, neither input asserted:
  - PC_WRITE_EN=1, ID_EX_BUBBLE=0.
  - Next edge: load all inputs, VALID_OUT=1.
- STALL:
  - PC_WRITE_EN=0, ID_EX_BUBBLE=1, IF/ID held, LOAD_USE ignored.
  - Counter decrements each cycle; at counter==1 the next state is RUN.
  - BRANCH_FLUSH=1 in STALL aborts the stall in the same cycle: PC_WRITE_EN=1, ID_EX_BUBBLE=0; next edge writes NOP, VALID_OUT=0, state RUN, counter=0.
- Latency: one cycle from input to output in normal flow. Total freeze per load-use event = STALL_CYCLES cycles exactly.
- Back-to-back hazards: LOAD_USE is re-evaluated in the first RUN cycle after a stall. A hazard still present then causes another stall; no merging.
- RESET mid-stall returns to RUN immediately, with the reset values above.
- Counter width is 3 bits; it never underflows and saturates at 0.
- PC_OUT and PC_PLUS4_OUT are not cleared on flush; only INSTRUCTION_OUT and VALID_OUT change.

Optional Feature:
- Macro: IF_ID_STALL_COUNTER_EN.
- When defined:
  - Adds output STALL_COUNT [31:0], a free-running count of cycles in which ID_EX_BUBBLE=1 due to load-use. Flush-only cycles are not counted.
  - Wraps 32'hFFFFFFFF -> 0; reset value 0.
  - Adds output FLUSH_COUNT [31:0], which increments on each cycle with BRANCH_FLUSH=1.
- When undefined: neither port exists, and the core behaviour is otherwise identical.

Test Plan:
- Reset then three sequential fetches (PC 0x0,0x4,0x8, instr 0x00500093…) -> outputs follow one cycle later; VALID_OUT=1 from the first edge; PC_WRITE_EN=1 throughout.
- LOAD_USE=1 for one cycle at PC 0x8, STALL_CYCLES=1 -> PC_WRITE_EN=0 and ID_EX_BUBBLE=1 that cycle; PC_OUT stays 0x4 for one extra edge, then advances to 0x8.
- STALL_CYCLES=3 with LOAD_USE pulsed once -> PC_WRITE_EN=0 for exactly 3 cycles; LOAD_USE toggled during STALL has no effect.
- BRANCH_FLUSH and LOAD_USE asserted together -> PC_WRITE_EN=1, ID_EX_BUBBLE=0; next edge INSTRUCTION_OUT=0x00000013, VALID_OUT=0.
- RESET asserted asynchronously mid-stall (STALL_CYCLES=3, second cycle) -> outputs reset immediately without a clock edge; PC_WRITE_EN=1 after RESET deasserts.
- With IF_ID_STALL_COUNTER_EN: two load-use events at STALL_CYCLES=2 plus one flush -> STALL_COUNT=4, FLUSH_COUNT=1.

Source files
------------

// File: rtl/if_id_stall_register.sv
// IF/ID pipeline register with an integrated load-use stall / branch flush
// controller for a 5-stage RV32IM pipeline.
//
// A load-use hazard freezes the PC and the IF/ID register for STALL_CYCLES
// cycles in total and requests a bubble into ID/EX for each of them. A taken
// branch/jump resolved in EX turns the next IF/ID slot into a NOP and aborts
// any stall in progress.
//
// Optional build macro: IF_ID_STALL_COUNTER_EN
//   When defined, adds STALL_COUNT (cycles with a load-use bubble) and
//   FLUSH_COUNT (cycles with BRANCH_FLUSH asserted) as 32-bit wrapping
//   performance counters.

module if_id_stall_register #(
  parameter int          XLEN         = 32,
  parameter int          STALL_CYCLES = 1,
  parameter logic [31:0] NOP_INSTR    = 32'h00000013
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [XLEN-1:0] PC_IN,
  input  logic [XLEN-1:0] PC_PLUS4_IN,
  input  logic [31:0]     INSTRUCTION_IN,
  input  logic            LOAD_USE,
  input  logic            BRANCH_FLUSH,
  output logic [XLEN-1:0] PC_OUT,
  output logic [XLEN-1:0] PC_PLUS4_OUT,
  output logic [31:0]     INSTRUCTION_OUT,
  output logic            VALID_OUT,
`ifdef IF_ID_STALL_COUNTER_EN
  output logic [31:0]     STALL_COUNT,
  output logic [31:0]     FLUSH_COUNT,
`endif
  output logic            PC_WRITE_EN,
  output logic            ID_EX_BUBBLE
);

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_t;

  // The stall cycle in which LOAD_USE is seen counts as the first freeze
  // cycle, so the counter only has to cover the remaining ones.
  localparam logic [2:0] STALL_INIT = 3'(STALL_CYCLES - 1);

  state_t     state_r;
  logic [2:0] count_r;
  logic       freeze_s;

  // Decide whether the current cycle freezes fetch; flush always wins.
  always_comb begin
    freeze_s = 1'b0;
    if (RESET) begin
      freeze_s = 1'b0;
    end else if (BRANCH_FLUSH) begin
      freeze_s = 1'b0;
    end else begin
      case (state_r)
        RUN:     freeze_s = LOAD_USE;
        STALL:   freeze_s = 1'b1;
        default: freeze_s = 1'b0;
      endcase
    end
  end

  assign PC_WRITE_EN  = ~freeze_s;
  assign ID_EX_BUBBLE = freeze_s;

  // IF/ID register contents, stall state and remaining-stall counter.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      PC_OUT          <= '0;
      PC_PLUS4_OUT    <= '0;
      INSTRUCTION_OUT <= NOP_INSTR;
      VALID_OUT       <= 1'b0;
      state_r         <= RUN;
      count_r         <= 3'd0;
    end else if (BRANCH_FLUSH) begin
      // PC fields keep flowing; only the instruction slot is killed.
      PC_OUT          <= PC_IN;
      PC_PLUS4_OUT    <= PC_PLUS4_IN;
      INSTRUCTION_OUT <= NOP_INSTR;
      VALID_OUT       <= 1'b0;
      state_r         <= RUN;
      count_r         <= 3'd0;
    end else begin
      case (state_r)
        RUN: begin
          if (LOAD_USE) begin
            count_r <= STALL_INIT;
            state_r <= (STALL_CYCLES == 1) ? RUN : STALL;
          end else begin
            PC_OUT          <= PC_IN;
            PC_PLUS4_OUT    <= PC_PLUS4_IN;
            INSTRUCTION_OUT <= INSTRUCTION_IN;
            VALID_OUT       <= 1'b1;
            count_r         <= 3'd0;
            state_r         <= RUN;
          end
        end
        STALL: begin
          // Counter saturates at zero; reaching one means this is the last
          // frozen cycle, and zero can only be a recovery path back to RUN.
          if (count_r != 3'd0) begin
            count_r <= count_r - 3'd1;
          end else begin
            count_r <= 3'd0;
          end
          if (count_r <= 3'd1) begin
            state_r <= RUN;
          end else begin
            state_r <= STALL;
          end
        end
        default: begin
          state_r <= RUN;
          count_r <= 3'd0;
        end
      endcase
    end
  end

`ifdef IF_ID_STALL_COUNTER_EN
  // Performance counters: load-use bubble cycles and branch flush cycles.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      STALL_COUNT <= 32'd0;
      FLUSH_COUNT <= 32'd0;
    end else begin
      if (freeze_s) begin
        STALL_COUNT <= STALL_COUNT + 32'd1;
      end else begin
        STALL_COUNT <= STALL_COUNT;
      end
      if (BRANCH_FLUSH) begin
        FLUSH_COUNT <= FLUSH_COUNT + 32'd1;
      end else begin
        FLUSH_COUNT <= FLUSH_COUNT;
      end
    end
  end
`endif

endmodule

// File: tb/tb_if_id_stall_register.sv
// Self-checking bench for if_id_stall_register. Three instances with
// STALL_CYCLES = 1, 3 and 2 share the same stimulus; each is compared with a
// behavioural model that tracks "frozen cycles still to go" as a plain integer.

module tb_if_id_stall_register;

  localparam logic [31:0] NOP = 32'h00000013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        lu;
  logic        fl;
  logic [31:0] pc_in;
  logic [31:0] pc4_in;
  logic [31:0] ins_in;

  logic [2:0][31:0] pc_o;
  logic [2:0][31:0] pc4_o;
  logic [2:0][31:0] ins_o;
  logic [2:0]       v_o;
  logic [2:0]       we_o;
  logic [2:0]       bub_o;
`ifdef IF_ID_STALL_COUNTER_EN
  logic [2:0][31:0] sc_o;
  logic [2:0][31:0] fc_o;
`endif

  genvar g;
  for (g = 0; g < 3; g++) begin : gen_dut
    if_id_stall_register #(
      .XLEN(32),
      .STALL_CYCLES((g == 0) ? 1 : ((g == 1) ? 3 : 2)),
      .NOP_INSTR(32'h00000013)
    ) u_dut (
      .CLK(clk),
      .RESET(rst),
      .PC_IN(pc_in),
      .PC_PLUS4_IN(pc4_in),
      .INSTRUCTION_IN(ins_in),
      .LOAD_USE(lu),
      .BRANCH_FLUSH(fl),
      .PC_OUT(pc_o[g]),
      .PC_PLUS4_OUT(pc4_o[g]),
      .INSTRUCTION_OUT(ins_o[g]),
      .VALID_OUT(v_o[g]),
`ifdef IF_ID_STALL_COUNTER_EN
      .STALL_COUNT(sc_o[g]),
      .FLUSH_COUNT(fc_o[g]),
`endif
      .PC_WRITE_EN(we_o[g]),
      .ID_EX_BUBBLE(bub_o[g])
    );
  end

  // ---------------- reference model ----------------
  int          s_of [3] = '{1, 3, 2};
  int          rem  [3];   // frozen cycles still to go, current one included
  logic [31:0] m_pc [3];
  logic [31:0] m_pc4[3];
  logic [31:0] m_ins[3];
  logic        m_v  [3];
  logic [31:0] m_sc [3];
  logic [31:0] m_fc [3];

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) begin
      rem[k] = 0; m_pc[k] = 32'd0; m_pc4[k] = 32'd0;
      m_ins[k] = NOP; m_v[k] = 1'b0; m_sc[k] = 32'd0; m_fc[k] = 32'd0;
    end
  endfunction

  function automatic logic frozen(int k);
    return !rst && !fl && (rem[k] > 0 || lu);
  endfunction

  function automatic void model_edge();
    for (int k = 0; k < 3; k++) begin
      if (frozen(k)) m_sc[k] = m_sc[k] + 32'd1;
      if (fl) m_fc[k] = m_fc[k] + 32'd1;
      if (fl) begin
        m_pc[k] = pc_in; m_pc4[k] = pc4_in; m_ins[k] = NOP; m_v[k] = 1'b0; rem[k] = 0;
      end else if (rem[k] > 0) begin
        rem[k] = rem[k] - 1;
      end else if (lu) begin
        rem[k] = s_of[k] - 1;
      end else begin
        m_pc[k] = pc_in; m_pc4[k] = pc4_in; m_ins[k] = ins_in; m_v[k] = 1'b1;
      end
    end
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d at %0t: got %h expected %h", nm, k, $time, act, exp);
    end
  endtask

  task automatic check_comb();
    for (int k = 0; k < 3; k++) begin
      chk("pc_write_en", k, 32'(we_o[k]), 32'(!frozen(k)));
      chk("id_ex_bubble", k, 32'(bub_o[k]), 32'(frozen(k)));
    end
  endtask

  task automatic check_regs();
    for (int k = 0; k < 3; k++) begin
      chk("pc_out", k, pc_o[k], m_pc[k]);
      chk("pc_plus4_out", k, pc4_o[k], m_pc4[k]);
      chk("instruction_out", k, ins_o[k], m_ins[k]);
      chk("valid_out", k, 32'(v_o[k]), 32'(m_v[k]));
`ifdef IF_ID_STALL_COUNTER_EN
      chk("stall_count", k, sc_o[k], m_sc[k]);
      chk("flush_count", k, fc_o[k], m_fc[k]);
`endif
    end
  endtask

  task automatic drive(input logic l, input logic f, input logic [31:0] p, input logic [31:0] i);
    lu = l; fl = f; pc_in = p; pc4_in = p + 32'd4; ins_in = i;
    #2;
    check_comb();
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_regs();
  endtask

  task automatic cycle(input logic l, input logic f, input logic [31:0] p, input logic [31:0] i);
    drive(l, f, p, i);
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1; lu = 1'b0; fl = 1'b0;
    #2;
    model_reset();
    check_regs();
    check_comb();
    @(posedge clk);
    #1;
    check_regs();
    rst = 1'b0;
  endtask

  typedef struct {
    logic        lu;
    logic        fl;
    logic [31:0] pc;
    logic [31:0] ins;
    logic        e_we;
    logic        e_bub;
    logic [31:0] e_pc;
    logic [31:0] e_ins;
    logic        e_v;
  } vec_t;

  vec_t tbl[8];
  int   nfz;

  initial begin
    // Expected values for the STALL_CYCLES=1 instance (dut0).
    tbl[0] = '{1'b0, 1'b0, 32'h0,  32'h00500093, 1'b1, 1'b0, 32'h0,  32'h00500093, 1'b1};
    tbl[1] = '{1'b0, 1'b0, 32'h4,  32'h00a00113, 1'b1, 1'b0, 32'h4,  32'h00a00113, 1'b1};
    tbl[2] = '{1'b1, 1'b0, 32'h8,  32'h0000a183, 1'b0, 1'b1, 32'h4,  32'h00a00113, 1'b1};
    tbl[3] = '{1'b0, 1'b0, 32'h8,  32'h0000a183, 1'b1, 1'b0, 32'h8,  32'h0000a183, 1'b1};
    tbl[4] = '{1'b1, 1'b1, 32'hC,  32'h00c00213, 1'b1, 1'b0, 32'hC,  32'h00000013, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 32'h10, 32'h00108093, 1'b0, 1'b1, 32'hC,  32'h00000013, 1'b0};
    tbl[6] = '{1'b1, 1'b0, 32'h10, 32'h00108093, 1'b0, 1'b1, 32'hC,  32'h00000013, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 32'h10, 32'h00108093, 1'b1, 1'b0, 32'h10, 32'h00108093, 1'b1};

    rst = 1'b1; lu = 1'b0; fl = 1'b0; pc_in = 32'd0; pc4_in = 32'd4; ins_in = 32'd0;
    model_reset();
    @(posedge clk);
    #1;
    chk("reset_instr_nop", 0, ins_o[0], 32'h00000013);
    chk("reset_valid", 0, 32'(v_o[0]), 32'd0);
    chk("reset_we", 0, 32'(we_o[0]), 32'd1);
    chk("reset_bubble", 0, 32'(bub_o[0]), 32'd0);
    check_regs();
    rst = 1'b0;

    // Table: fetch sequence, S=1 stall, flush+load-use, back-to-back stalls.
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].lu, tbl[i].fl, tbl[i].pc, tbl[i].ins);
      chk("tbl_we", 0, 32'(we_o[0]), 32'(tbl[i].e_we));
      chk("tbl_bub", 0, 32'(bub_o[0]), 32'(tbl[i].e_bub));
      tick();
      chk("tbl_pc", 0, pc_o[0], tbl[i].e_pc);
      chk("tbl_ins", 0, ins_o[0], tbl[i].e_ins);
      chk("tbl_valid", 0, 32'(v_o[0]), 32'(tbl[i].e_v));
    end

    // STALL_CYCLES=3: single pulse freezes exactly 3 cycles; LOAD_USE
    // toggled during the stall is ignored.
    do_reset();
    cycle(1'b0, 1'b0, 32'h100, 32'h00500093);
    nfz = 0;
    for (int i = 0; i < 6; i++) begin
      drive((i == 0 || i == 2) ? 1'b1 : 1'b0, 1'b0, 32'h104, 32'h0000a183);
      if (!we_o[1]) nfz++;
      tick();
    end
    chk("s3_freeze_len", 1, 32'(nfz), 32'd3);
    chk("s3_pc_after", 1, pc_o[1], 32'h104);

    // Flush and load-use together: flush wins.
    cycle(1'b0, 1'b0, 32'h200, 32'h00a00113);
    drive(1'b1, 1'b1, 32'h204, 32'h00c00213);
    chk("flush_lu_we", 1, 32'(we_o[1]), 32'd1);
    chk("flush_lu_bub", 1, 32'(bub_o[1]), 32'd0);
    tick();
    chk("flush_lu_ins", 1, ins_o[1], 32'h00000013);
    chk("flush_lu_valid", 1, 32'(v_o[1]), 32'd0);
    chk("flush_lu_pc", 1, pc_o[1], 32'h204);

    // Flush aborting a stall in progress (dut1 in its second frozen cycle).
    cycle(1'b1, 1'b0, 32'h300, 32'h00108093);
    drive(1'b0, 1'b1, 32'h304, 32'h00208093);
    chk("stall_abort_we", 1, 32'(we_o[1]), 32'd1);
    tick();
    cycle(1'b0, 1'b0, 32'h308, 32'h00308093);
    chk("stall_abort_resume", 1, pc_o[1], 32'h308);

    // Asynchronous reset in the second cycle of an S=3 stall.
    cycle(1'b1, 1'b0, 32'h400, 32'h00408093);
    drive(1'b0, 1'b0, 32'h404, 32'h00508093);
    chk("mid_stall_we", 1, 32'(we_o[1]), 32'd0);
    rst = 1'b1;
    #1;
    model_reset();
    chk("async_rst_pc", 1, pc_o[1], 32'd0);
    chk("async_rst_ins", 1, ins_o[1], 32'h00000013);
    chk("async_rst_we", 1, 32'(we_o[1]), 32'd1);
    check_regs();
    check_comb();
    #1;
    rst = 1'b0;
    cycle(1'b0, 1'b0, 32'h404, 32'h00508093);
    chk("post_rst_we", 1, 32'(we_o[1]), 32'd1);
    chk("post_rst_pc", 1, pc_o[1], 32'h404);

`ifdef IF_ID_STALL_COUNTER_EN
    // Two load-use events at S=2 plus one flush.
    do_reset();
    cycle(1'b1, 1'b0, 32'h500, 32'h00500093);
    cycle(1'b0, 1'b0, 32'h500, 32'h00500093);
    cycle(1'b1, 1'b0, 32'h504, 32'h00a00113);
    cycle(1'b0, 1'b0, 32'h504, 32'h00a00113);
    cycle(1'b0, 1'b1, 32'h508, 32'h00c00213);
    cycle(1'b0, 1'b0, 32'h600, 32'h00108093);
    chk("cnt_stall_s2", 2, sc_o[2], 32'd4);
    chk("cnt_flush_s2", 2, fc_o[2], 32'd1);
`endif

    // Randomized stimulus against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        cycle(($urandom_range(0, 99) < 30) ? 1'b1 : 1'b0,
              ($urandom_range(0, 99) < 10) ? 1'b1 : 1'b0,
              $urandom & 32'hFFFF_FFFC, $urandom);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
